// File: rtl/traffic_pkg.sv
// Shared lane indices, phase encoding, light decode and default timing for the
// intersection lane scheduler.
package traffic_pkg;

  localparam logic [1:0] LANE_NS1 = 2'd0;
  localparam logic [1:0] LANE_NS2 = 2'd1;
  localparam logic [1:0] LANE_EW1 = 2'd2;
  localparam logic [1:0] LANE_EW2 = 2'd3;

  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_EXT_GREEN = 8;
  localparam int DEF_MAX_GREEN = 32;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_CLEAR_T   = 2;
  localparam int DEF_CNT_W     = 6;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_CLEAR  = 2'd3
  } phase_e;

  // Existing light code: 0 all red, lane L green = 2L+1, lane L yellow = 2L+2.
  function automatic logic [3:0] light_encode(input phase_e ph, input logic [1:0] lane);
    logic [3:0] base;
    base = {1'b0, lane, 1'b0};
    case (ph)
      PH_GREEN:  light_encode = base + 4'd1;
      PH_YELLOW: light_encode = base + 4'd2;
      default:   light_encode = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/lane_rr_arbiter.sv
// Combinational 4-way round-robin pick: first set request searching upward
// (with wrap) from last+1.
module lane_rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  logic [1:0] cand;

  // Walk from the farthest offset down so the nearest candidate wins.
  always_comb begin
    gnt_idx = last;
    gnt_vld = 1'b0;
    cand    = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_phase_scheduler.sv
// Lane phase scheduler: latches lane requests, grants round-robin or by emergency,
// and walks GREEN -> YELLOW -> CLEAR on a tick-prescaled dwell timer.
module lane_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int EXT_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW_T  = 3,
  parameter int CLEAR_T   = 2,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic [3:0] cong,
  input  logic       emerg_valid,
  input  logic [1:0] emerg_lane,
  output logic [1:0] active_lane,
  output logic [1:0] phase,
  output logic [3:0] pending,
  output logic       grant_pulse,
  output logic [3:0] light_signal
);

  localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] CLR_M1 = CNT_W'(CLEAR_T - 1);
  localparam logic [CNT_W:0]   EXT_W  = (CNT_W + 1)'(EXT_GREEN);
  localparam logic [CNT_W:0]   MAX_W  = (CNT_W + 1)'(MAX_GREEN);

  phase_e           phase_q, phase_d;
  logic [1:0]       active_q, active_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             ext_used_q, ext_used_d;
  logic             grant_pulse_q, grant_pulse_d;

  logic [1:0]       rr_idx;
  logic             rr_vld;
  logic             grant;
  logic [1:0]       grant_lane;
  logic             emerg_same;
  logic             emerg_other;
  logic [CNT_W:0]   ext_sum;
  logic             can_extend;

  lane_rr_arbiter u_arb (
    .req     (pending_q),
    .last    (last_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign emerg_same  = emerg_valid && (emerg_lane == active_q);
  assign emerg_other = emerg_valid && (emerg_lane != active_q);
  assign ext_sum     = {1'b0, limit_q} + EXT_W;
  assign can_extend  = cong[active_q] && !ext_used_q && (ext_sum <= MAX_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH_IDLE;
      active_q      <= LANE_NS1;
      last_q        <= LANE_EW2;
      pending_q     <= 4'd0;
      cnt_q         <= '0;
      limit_q       <= MIN_G;
      ext_used_q    <= 1'b0;
      grant_pulse_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      active_q      <= active_d;
      last_q        <= last_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      limit_q       <= limit_d;
      ext_used_q    <= ext_used_d;
      grant_pulse_q <= grant_pulse_d;
    end
  end

  always_comb begin
    phase_d       = phase_q;
    active_d      = active_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    limit_d       = limit_q;
    ext_used_d    = ext_used_q;
    grant_pulse_d = 1'b0;
    grant         = 1'b0;
    grant_lane    = rr_idx;

    case (phase_q)
      PH_IDLE: begin
        if (emerg_valid) begin
          grant      = 1'b1;
          grant_lane = emerg_lane;
        end else if (rr_vld) begin
          grant = 1'b1;
        end
        if (grant) begin
          phase_d       = PH_GREEN;
          active_d      = grant_lane;
          last_d        = grant_lane;
          cnt_d         = '0;
          ext_used_d    = 1'b0;
          limit_d       = MIN_G;
          grant_pulse_d = 1'b1;
        end
      end
      PH_GREEN: begin
        // A competing emergency aborts green at once, ignoring tick and min green.
        if (emerg_other) begin
          phase_d    = PH_YELLOW;
          cnt_d      = '0;
          ext_used_d = 1'b0;
        end else if (tick) begin
          if (emerg_same) begin
            if (cnt_q == MAX_M1) begin
              phase_d    = PH_YELLOW;
              cnt_d      = '0;
              ext_used_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (cnt_q >= limit_q - 1'b1) begin
            if (can_extend) begin
              limit_d    = ext_sum[CNT_W-1:0];
              ext_used_d = 1'b1;
              cnt_d      = cnt_q + 1'b1;
            end else begin
              phase_d    = PH_YELLOW;
              cnt_d      = '0;
              ext_used_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PH_YELLOW: begin
        if (tick) begin
          if (cnt_q == YEL_M1) begin
            phase_d    = PH_CLEAR;
            cnt_d      = '0;
            ext_used_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (tick) begin
          if (cnt_q == CLR_M1) begin
            phase_d    = PH_IDLE;
            cnt_d      = '0;
            ext_used_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase

    // The granted lane drops its bit; a same-cycle request for it is ignored.
    pending_d = pending_q | req;
    if (grant) pending_d[grant_lane] = 1'b0;
  end

  assign active_lane  = active_q;
  assign phase        = phase_q;
  assign pending      = pending_q;
  assign grant_pulse  = grant_pulse_q;
  assign light_signal = light_encode(phase_q, active_q);

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Directed bench for lane_phase_scheduler with a scoreboard of per-cycle
// expected {grant_pulse, light_signal, pending}.
module tb_lane_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] cong = 4'd0;
  logic       emerg_valid = 1'b0;
  logic [1:0] emerg_lane = 2'd0;
  logic [1:0] active_lane;
  logic [1:0] phase;
  logic [3:0] pending;
  logic       grant_pulse;
  logic [3:0] light_signal;

  typedef struct packed {
    logic       gp;
    logic [3:0] light;
    logic [3:0] pend;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   pc = 0;
  bit   presc = 1'b0;

  lane_phase_scheduler #(
    .MIN_GREEN (4),
    .EXT_GREEN (2),
    .MAX_GREEN (8),
    .YELLOW_T  (2),
    .CLEAR_T   (1),
    .CNT_W     (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .req          (req),
    .cong         (cong),
    .emerg_valid  (emerg_valid),
    .emerg_lane   (emerg_lane),
    .active_lane  (active_lane),
    .phase        (phase),
    .pending      (pending),
    .grant_pulse  (grant_pulse),
    .light_signal (light_signal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    pc++;
    if (presc) tick = ((pc % 4) == 1);
  endtask

  task automatic push_one(input logic gp, input int light, input logic [3:0] pend);
    exp_t e;
    e.gp    = gp;
    e.light = 4'(light);
    e.pend  = pend;
    sb.push_back(e);
  endtask

  // One full service of a lane: green, yellow, clear, then one idle cycle.
  task automatic push_seq(input int lane, input logic [3:0] pend, input int g, input int y, input int c);
    for (int i = 0; i < g; i++) push_one(i == 0, 2 * lane + 1, pend);
    for (int i = 0; i < y; i++) push_one(1'b0, 2 * lane + 2, pend);
    for (int i = 0; i < c; i++) push_one(1'b0, 0, pend);
    push_one(1'b0, 0, pend);
  endtask

  task automatic drain_n(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) break;
      next_cycle();
      e = sb.pop_front();
      check($sformatf("%s%0d", tag, i), {7'd0, grant_pulse, light_signal, pending}, {7'd0, e});
    end
  endtask

  task automatic drain_all(input string tag);
    drain_n(tag, sb.size());
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    req = 4'd0;
    cong = 4'd0;
    emerg_valid = 1'b0;
    presc = 1'b0;
    tick = 1'b1;
    next_cycle();
    next_cycle();
    check(tag, {3'd0, phase, active_lane, pending, grant_pulse, light_signal}, 16'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic single-lane cycle
    do_reset("rst0");
    req = 4'b0001;
    next_cycle();
    check("t1_pend", 16'(pending), 16'h1);
    req = 4'b0000;
    push_seq(0, 4'b0000, 4, 2, 1);
    drain_all("t1_");

    // Round-robin over all four lanes
    do_reset("rst1");
    req = 4'b1111;
    next_cycle();
    check("t2_pend", 16'(pending), 16'hf);
    req = 4'b0000;
    push_seq(0, 4'b1110, 4, 2, 1);
    push_seq(1, 4'b1100, 4, 2, 1);
    push_seq(2, 4'b1000, 4, 2, 1);
    push_seq(3, 4'b0000, 4, 2, 1);
    drain_all("t2_");

    // Single congestion extension
    do_reset("rst2");
    cong = 4'b0001;
    req = 4'b0001;
    next_cycle();
    req = 4'b0000;
    push_seq(0, 4'b0000, 6, 2, 1);
    drain_all("t3_");
    cong = 4'b0000;

    // Emergency for EW1 preempts NS1 ahead of pending NS2
    do_reset("rst3");
    req = 4'b0011;
    next_cycle();
    req = 4'b0000;
    push_seq(0, 4'b0010, 2, 2, 1);
    push_seq(2, 4'b0010, 4, 2, 1);
    push_seq(1, 4'b0000, 4, 2, 1);
    drain_n("t4a_", 2);
    emerg_valid = 1'b1;
    emerg_lane = 2'd2;
    drain_n("t4b_", 5);
    emerg_valid = 1'b0;
    check("t4_active", 16'(active_lane), 16'd2);
    drain_all("t4c_");

    // Tick every fourth cycle
    do_reset("rst4");
    pc = 0;
    presc = 1'b1;
    tick = 1'b0;
    req = 4'b0001;
    next_cycle();
    req = 4'b0000;
    push_seq(0, 4'b0000, 16, 8, 4);
    drain_all("t5_");
    presc = 1'b0;
    tick = 1'b1;

    // Reset during EW2 yellow
    do_reset("rst5");
    req = 4'b1000;
    next_cycle();
    req = 4'b0000;
    push_one(1'b1, 7, 4'b0000);
    push_one(1'b0, 7, 4'b0001);
    push_one(1'b0, 7, 4'b0001);
    push_one(1'b0, 7, 4'b0001);
    push_one(1'b0, 8, 4'b0001);
    drain_n("t6a_", 1);
    req = 4'b0001;
    drain_n("t6b_", 1);
    req = 4'b0000;
    drain_n("t6c_", 3);
    rst = 1'b1;
    next_cycle();
    check("t6_rst", {3'd0, phase, active_lane, pending, grant_pulse, light_signal}, 16'd0);
    rst = 1'b0;
    req = 4'b0010;
    next_cycle();
    req = 4'b0000;
    check("t6_pend", 16'(pending), 16'h2);
    push_seq(1, 4'b0000, 4, 2, 1);
    drain_n("t6d_", 1);
    check("t6_active", 16'(active_lane), 16'd1);
    drain_all("t6e_");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
